// File: rtl/div_seq.sv
// div_seq -- sequential signed fixed-point divider.
//
// Computes Q = A * 2^F / X using a restoring algorithm on the operand
// magnitudes, one quotient bit per clock, MSB first. The raw magnitude is
// re-signed and saturated symmetrically to N bits, so -2^(N-1) is never
// produced. Work is requested with a start/ready handshake, and the result
// is announced by a one-cycle done strobe.
//
// Ports
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   start  in   1  request, sampled only while ready=1
//   A      in   N  signed dividend
//   X      in   M  signed divisor
//   ready  out  1  idle and able to accept start
//   done   out  1  one-cycle result strobe
//   Q      out  N  signed quotient, held until the next done
//   ovf    out  1  quotient saturated, valid with done and held
//   dz     out  1  divide by zero, valid with done and held
module div_seq #(
  parameter int N = 8,
  parameter int M = N,
  parameter int F = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [M-1:0] X,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] Q,
  output logic         ovf,
  output logic         dz
);

  localparam int W  = N + F;            // dividend / raw quotient width
  localparam int CW = $clog2(W + 1);    // step counter width

  // Largest positive quotient and its symmetric negative counterpart.
  localparam logic [N-1:0] QMAX     = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] QSAT_NEG = {1'b1, {(N-2){1'b0}}, 1'b1};
  localparam logic [W-1:0] QMAX_W   = {{(F+1){1'b0}}, {(N-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [CW-1:0] count_reg;
  logic [W-1:0]  dvd_reg;    // |A| * 2^F, consumed MSB first
  logic [W-1:0]  quo_reg;    // raw quotient magnitude
  logic [M-1:0]  rem_reg;    // partial remainder, always < |X|
  logic [M-1:0]  xmag_reg;   // |X|
  logic          sa_reg;
  logic          sq_reg;
  logic          dzp_reg;    // divide-by-zero pending for FIX
  logic [N-1:0]  q_reg;
  logic          ovf_reg;
  logic          dz_reg;
  logic          done_reg;

  // Operand magnitudes. Plain N-bit negation maps -2^(N-1) onto the
  // unsigned value 2^(N-1), which is exactly the magnitude wanted.
  logic [N-1:0] a_abs;
  logic [M-1:0] x_abs;
  assign a_abs = A[N-1] ? (-A) : A;
  assign x_abs = X[M-1] ? (-X) : X;

  // One restoring step. The remainder is below |X| <= 2^(M-1), so the
  // shifted value fits M+1 bits and the trial difference fits a signed
  // M+1-bit value: its MSB is the borrow, i.e. "shifted < |X|".
  logic [M:0]   rem_shift;
  logic [M:0]   rem_diff;
  logic         q_bit;
  logic [M-1:0] rem_step;
  assign rem_shift = {rem_reg, dvd_reg[W-1]};
  assign rem_diff  = rem_shift - {1'b0, xmag_reg};
  assign q_bit     = ~rem_diff[M];
  assign rem_step  = q_bit ? rem_diff[M-1:0] : rem_shift[M-1:0];

  // Final sign application and saturation.
  logic [N-1:0] q_mag;
  logic [N-1:0] q_fix;
  logic         ovf_fix;
  assign q_mag = quo_reg[N-1:0];

  always_comb begin
    q_fix   = '0;
    ovf_fix = 1'b0;
    if (dzp_reg) begin
      q_fix = sa_reg ? QSAT_NEG : QMAX;
    end else if (quo_reg > QMAX_W) begin
      q_fix   = sq_reg ? QSAT_NEG : QMAX;
      ovf_fix = 1'b1;
    end else begin
      // Negating zero yields zero, so a zero dividend needs no special case.
      q_fix = sq_reg ? (-q_mag) : q_mag;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (X == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        if (count_reg == '0) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      dvd_reg   <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      xmag_reg  <= '0;
      sa_reg    <= 1'b0;
      sq_reg    <= 1'b0;
      dzp_reg   <= 1'b0;
      q_reg     <= '0;
      ovf_reg   <= 1'b0;
      dz_reg    <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            xmag_reg  <= x_abs;
            sa_reg    <= A[N-1];
            sq_reg    <= A[N-1] ^ X[M-1];
            rem_reg   <= '0;
            quo_reg   <= '0;
            dvd_reg   <= {a_abs, {F{1'b0}}};
            dzp_reg   <= (x_abs == '0);
            count_reg <= CW'(W - 1);
          end
        end
        CALC: begin
          rem_reg <= rem_step;
          dvd_reg <= {dvd_reg[W-2:0], 1'b0};
          quo_reg <= {quo_reg[W-2:0], q_bit};
          if (count_reg != '0) begin
            count_reg <= count_reg - CW'(1);
          end
        end
        FIX: begin
          q_reg    <= q_fix;
          ovf_reg  <= ovf_fix;
          dz_reg   <= dzp_reg;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready = (state_reg == IDLE);
  assign done  = done_reg;
  assign Q     = q_reg;
  assign ovf   = ovf_reg;
  assign dz    = dz_reg;

endmodule

// File: tb/tb_div_seq.sv
// Testbench for div_seq (defaults N=8, M=8, F=4).
// A transaction-level reference (plain integer division on magnitudes with
// saturation, plus an accept-to-done cycle count) predicts ready/done/Q/ovf/dz
// on every cycle; directed operations also check hand-computed literals.
module tb_div_seq;

  localparam int N    = 8;
  localparam int M    = 8;
  localparam int F    = 4;
  localparam int W    = N + F;
  localparam int QMAX = (1 << (N - 1)) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a;
  logic [M-1:0] x;
  logic         ready;
  logic         done;
  logic [N-1:0] q;
  logic         ovf;
  logic         dz;

  always #5 clk = ~clk;

  div_seq #(.N(N), .M(M), .F(F)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a),
    .X     (x),
    .ready (ready),
    .done  (done),
    .Q     (q),
    .ovf   (ovf),
    .dz    (dz)
  );

  int checks = 0;
  int errors = 0;

  // Reference state
  bit           m_busy;
  int           m_cnt;
  bit           m_done;
  logic [N-1:0] m_q;
  bit           m_ovf;
  bit           m_dz;
  logic [N-1:0] p_q;
  bit           p_ovf;
  bit           p_dz;

  function automatic void ref_div(input int av, input int xv,
                                  output logic [N-1:0] rq,
                                  output bit rovf, output bit rdz);
    int mag;
    bit neg;
    rovf = 1'b0;
    rdz  = 1'b0;
    if (xv == 0) begin
      rdz = 1'b1;
      mag = QMAX;
      neg = (av < 0);
    end else begin
      mag = ((av < 0 ? -av : av) * (1 << F)) / (xv < 0 ? -xv : xv);
      neg = ((av < 0) != (xv < 0));
      if (mag > QMAX) begin
        mag  = QMAX;
        rovf = 1'b1;
      end
    end
    rq = neg ? N'(-mag) : N'(mag);
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_cnt  = 0;
    m_done = 1'b0;
    m_q    = '0;
    m_ovf  = 1'b0;
    m_dz   = 1'b0;
  endtask

  // Advance the reference by one clock edge using the inputs seen there.
  task automatic model_update();
    if (!rst_n) begin
      model_reset();
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (m_cnt == 1) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_q    = p_q;
          m_ovf  = p_ovf;
          m_dz   = p_dz;
        end else begin
          m_cnt = m_cnt - 1;
        end
      end else if (start) begin
        ref_div(int'($signed(a)), int'($signed(x)), p_q, p_ovf, p_dz);
        m_busy = 1'b1;
        m_cnt  = (x == '0) ? 1 : W + 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic compare();
    chk("ready", 32'(ready), 32'(!m_busy));
    chk("done",  32'(done),  32'(m_done));
    chk("Q",     32'(q),     32'(m_q));
    chk("ovf",   32'(ovf),   32'(m_ovf));
    chk("dz",    32'(dz),    32'(m_dz));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  // Issue one operation and wait for its done. With lit set, the result is
  // also checked against the given hand-computed values. With spam set,
  // start is held high with junk operands throughout the calculation.
  task automatic run_op(input int av, input int xv, input bit lit,
                        input logic [N-1:0] eq, input bit eovf, input bit edz,
                        input bit spam);
    int  n;
    bit  got;
    int  elat;
    elat = (xv == 0) ? 1 : W + 1;
    chk("ready_before_start", 32'(ready), 32'd1);
    a     = N'(av);
    x     = M'(xv);
    start = 1'b1;
    tick();
    start = 1'b0;
    n     = 0;
    got   = 1'b0;
    while (!got && n < 40) begin
      if (spam) begin
        start = 1'b1;
        a     = N'($urandom);
        x     = M'($urandom);
      end
      tick();
      n++;
      if (done === 1'b1) got = 1'b1;
    end
    start = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout A=%0d X=%0d: no done within %0d cycles, expected after %0d",
               av, xv, n, elat);
    end else begin
      chk("latency", 32'(n), 32'(elat));
      if (lit) begin
        chk("Q_literal",   32'(q),   32'(eq));
        chk("ovf_literal", 32'(ovf), 32'(eovf));
        chk("dz_literal",  32'(dz),  32'(edz));
      end
    end
    $display("op A=%0d X=%0d -> Q=0x%02h (%0d) ovf=%0b dz=%0b latency=%0d",
             av, xv, q, $signed(q), ovf, dz, n);
  endtask

  function automatic int pick();
    case ($urandom_range(0, 5))
      0:       return -128;
      1:       return 127;
      2:       return -1;
      3:       return 0;
      4:       return 1;
      default: return int'($signed(8'($urandom)));
    endcase
  endfunction

  initial begin
    int ndone;
    int ra;
    int rx;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    x     = '0;
    model_reset();

    // Reset state
    tick();
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_done",  32'(done),  32'd0);
    chk("reset_Q",     32'(q),     32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Directed values, issued back-to-back (each start lands in the
    // previous done cycle).
    run_op(3,    2,  1'b1, 8'h18, 1'b0, 1'b0, 1'b0);
    run_op(-3,   2,  1'b1, 8'hE8, 1'b0, 1'b0, 1'b0);
    run_op(7,    -3, 1'b1, 8'hDB, 1'b0, 1'b0, 1'b0);
    run_op(100,  1,  1'b1, 8'h7F, 1'b1, 1'b0, 1'b0);
    run_op(-128, 1,  1'b1, 8'h81, 1'b1, 1'b0, 1'b0);
    run_op(5,    0,  1'b1, 8'h7F, 1'b0, 1'b1, 1'b0);
    run_op(-5,   0,  1'b1, 8'h81, 1'b0, 1'b1, 1'b0);
    run_op(0,    -7, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    run_op(-1,   -128, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);

    // Start held high during CALC must not disturb the running operation.
    tick();
    run_op(7, 2, 1'b1, 8'h38, 1'b0, 1'b0, 1'b1);
    tick();
    tick();

    // Reset in the middle of CALC aborts the operation without a done.
    a     = 8'd3;
    x     = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare();
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done",  32'(done),  32'd0);
    chk("abort_Q",     32'(q),     32'd0);
    tick();
    #2;
    rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    chk("no_done_after_abort", 32'(ndone), 32'd0);

    // Random and extreme operand pairs against the reference.
    for (int i = 0; i < 40; i++) begin
      ra = pick();
      rx = pick();
      run_op(ra, rx, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) tick();
    end
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
